// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared TS constants, null-packet header bytes and framer state encodings
package ts_pkg;

  localparam logic [7:0] TS_SYNC_WORD  = 8'h47;
  localparam int         TS_PKT_LEN    = 188;
  localparam logic [7:0] TS_STUFF_BYTE = 8'hFF;

  // Null packet header after the sync byte: PID 0x1FFF, payload only, CC 0
  localparam logic [7:0] TS_NULL_HDR1 = 8'h1F;
  localparam logic [7:0] TS_NULL_HDR2 = 8'hFF;
  localparam logic [7:0] TS_NULL_HDR3 = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_DATA = 3'b010,
    ST_NULL = 3'b100
  } ts_state_t;

endpackage

// File: rtl/ts_null_rom.sv
// rtl/ts_null_rom.sv - combinational byte index to null-packet byte lookup
module ts_null_rom
  import ts_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD  = TS_SYNC_WORD,
  parameter logic [7:0] STUFF_BYTE = TS_STUFF_BYTE
) (
  input  logic [7:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = STUFF_BYTE;
    case (idx)
      8'd0:    data = SYNC_WORD;
      8'd1:    data = TS_NULL_HDR1;
      8'd2:    data = TS_NULL_HDR2;
      8'd3:    data = TS_NULL_HDR3;
      default: data = STUFF_BYTE;
    endcase
  end

endmodule

// File: rtl/ts_tx_framer.sv
// rtl/ts_tx_framer.sv - drains TS packets from a FWFT FIFO into a slot-paced framed byte stream
// TS_NULL_PKT_EN: when defined, idle slots are filled with null packets for constant-rate output.
module ts_tx_framer
  import ts_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD  = TS_SYNC_WORD,
  parameter int         PKT_LEN    = TS_PKT_LEN,
  parameter logic [7:0] STUFF_BYTE = TS_STUFF_BYTE
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        tx_slot,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic        pkt_rdy,
  output logic        fifo_rd,
  output logic [7:0]  ts_out,
  output logic        ts_out_valid,
  output logic        ts_out_sync,
  output logic        ts_out_last,
  output logic        ts_out_null,
  output logic        sync_err,
  output logic        underrun,
  output logic [15:0] pkt_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  ts_state_t  state;
  logic [7:0] byte_cnt;
  logic [7:0] null_byte;
  logic [7:0] data_byte;
  logic       sync_bad;
  logic       last_byte;
  logic       take_data;
  logic       take_null;
  logic       in_idle;

  assign in_idle   = (state == ST_IDLE);
  assign take_data = tx_slot & ((state == ST_DATA) | (in_idle & pkt_rdy));
  assign fifo_rd   = take_data & ~fifo_empty;
  assign last_byte = (byte_cnt == LAST_IDX);

  // Sync is checked only on a real FIFO byte; an empty FIFO is reported as underrun instead
  assign sync_bad  = (byte_cnt == 8'd0) & ~fifo_empty & (fifo_dout != SYNC_WORD);
  assign data_byte = fifo_empty ? STUFF_BYTE : (sync_bad ? SYNC_WORD : fifo_dout);

`ifdef TS_NULL_PKT_EN
  assign take_null = tx_slot & ((state == ST_NULL) | (in_idle & ~pkt_rdy));

  ts_null_rom #(
    .SYNC_WORD  (SYNC_WORD),
    .STUFF_BYTE (STUFF_BYTE)
  ) u_null_rom (
    .idx  (byte_cnt),
    .data (null_byte)
  );
`else
  assign take_null = 1'b0;
  assign null_byte = STUFF_BYTE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      byte_cnt     <= 8'd0;
      ts_out       <= 8'h00;
      ts_out_valid <= 1'b0;
      ts_out_sync  <= 1'b0;
      ts_out_last  <= 1'b0;
      ts_out_null  <= 1'b0;
      sync_err     <= 1'b0;
      underrun     <= 1'b0;
      pkt_cnt      <= 16'd0;
    end else begin
      ts_out       <= 8'h00;
      ts_out_valid <= 1'b0;
      ts_out_sync  <= 1'b0;
      ts_out_last  <= 1'b0;
      ts_out_null  <= 1'b0;
      sync_err     <= 1'b0;
      underrun     <= 1'b0;
      if (take_data || take_null) begin
        ts_out_valid <= 1'b1;
        ts_out       <= take_data ? data_byte : null_byte;
        ts_out_sync  <= (byte_cnt == 8'd0);
        ts_out_last  <= last_byte;
        ts_out_null  <= take_null;
        sync_err     <= take_data & sync_bad;
        underrun     <= take_data & fifo_empty;
        if (in_idle && take_data)
          pkt_cnt <= pkt_cnt + 16'd1;
        // Framing is kept by slot count alone, so underrun bytes still advance byte_cnt
        if (last_byte) begin
          byte_cnt <= 8'd0;
          state    <= ST_IDLE;
        end else begin
          byte_cnt <= byte_cnt + 8'd1;
          if (in_idle) begin
`ifdef TS_NULL_PKT_EN
            state <= take_data ? ST_DATA : ST_NULL;
`else
            state <= ST_DATA;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ts_tx_framer.sv
// tb/tb_ts_tx_framer.sv - directed scoreboard bench for ts_tx_framer
module tb_ts_tx_framer;

  logic        rst;
  logic        clk = 1'b0;
  logic        tx_slot;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        pkt_rdy;
  logic        fifo_rd;
  logic [7:0]  ts_out;
  logic        ts_out_valid;
  logic        ts_out_sync;
  logic        ts_out_last;
  logic        ts_out_null;
  logic        sync_err;
  logic        underrun;
  logic [15:0] pkt_cnt;

  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  int          valid_cnt = 0;
  int          rd_base;
  bit          force_empty;
  logic [7:0]  fifo_q[$];
  logic [12:0] exp_q[$];
  logic [7:0]  pkt[188];

  ts_tx_framer dut (
    .rst          (rst),
    .clk          (clk),
    .tx_slot      (tx_slot),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .pkt_rdy      (pkt_rdy),
    .fifo_rd      (fifo_rd),
    .ts_out       (ts_out),
    .ts_out_valid (ts_out_valid),
    .ts_out_sync  (ts_out_sync),
    .ts_out_last  (ts_out_last),
    .ts_out_null  (ts_out_null),
    .sync_err     (sync_err),
    .underrun     (underrun),
    .pkt_cnt      (pkt_cnt)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void fifo_update();
    fifo_empty = force_empty || (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endfunction

  // One clock cycle, entered and left at posedge+1; the FIFO model pops after the DUT's edge
  task automatic cycle(input bit slot);
    bit rd;
    tx_slot = slot;
    fifo_update();
    #1;
    rd = fifo_rd;
    if (rd) rd_cnt++;
    @(posedge clk);
    #1;
    if (rd) void'(fifo_q.pop_front());
    tx_slot = 1'b0;
    fifo_update();
  endtask

  task automatic push_exp(input logic [7:0] d, input bit s, input bit l, input bit n,
                          input bit se, input bit ur);
    exp_q.push_back({d, s, l, n, se, ur});
  endtask

  task automatic fill_pkt(input logic [7:0] b0, input logic [7:0] seed);
    pkt[0] = b0;
    for (int i = 1; i < 188; i++) pkt[i] = 8'(i - 1) * 8'h11 + seed;
    for (int i = 0; i < 188; i++) fifo_q.push_back(pkt[i]);
    fifo_update();
  endtask

  task automatic push_pkt(input int nbytes);
    for (int k = 0; k < nbytes; k++)
      push_exp((k == 0) ? 8'h47 : pkt[k], k == 0, k == 187, 1'b0,
               (k == 0) && (pkt[0] != 8'h47), 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ts_out_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0)
          check("unexpected_valid", {31'd0, ts_out_valid}, 32'd0);
        else
          check("byte", {ts_out, ts_out_sync, ts_out_last, ts_out_null, sync_err, underrun},
                exp_q.pop_front());
      end else begin
        check("idle_zero", {ts_out, ts_out_sync, ts_out_last, ts_out_null, sync_err, underrun}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    tx_slot = 1'b0;
    pkt_rdy = 1'b0;
    force_empty = 1'b0;
    fifo_update();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ts_out, ts_out_valid, ts_out_sync, ts_out_last, ts_out_null,
                            sync_err, underrun, fifo_rd, pkt_cnt}, 32'd0);
    rst = 1'b0;

`ifdef TS_NULL_PKT_EN
    for (int k = 0; k < 188; k++)
      push_exp((k == 0) ? 8'h47 : (k == 1) ? 8'h1F : (k == 3) ? 8'h10 : 8'hFF,
               k == 0, k == 187, 1'b1, 1'b0, 1'b0);
    repeat (188) begin
      cycle(1'b1);
      repeat (3) cycle(1'b0);
    end
    check("null_left", exp_q.size(), 0);
`else
    repeat (500) cycle(1'b1);
    check("skip_valid_cnt", valid_cnt, 0);
`endif
    check("idle_no_rd", rd_cnt, 0);

    // Two packets back-to-back at full slot rate
    fill_pkt(8'h47, 8'h00);
    push_pkt(188);
    fill_pkt(8'h47, 8'h5A);
    push_pkt(188);
    pkt_rdy = 1'b1;
    repeat (376) cycle(1'b1);
    pkt_rdy = 1'b0;
    repeat (2) cycle(1'b0);
    check("b2b_rd_cnt", rd_cnt, 376);
    check("b2b_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
    check("b2b_left", exp_q.size(), 0);

    // Bad sync byte is repaired
    rd_base = rd_cnt;
    fill_pkt(8'h46, 8'h03);
    push_pkt(188);
    pkt_rdy = 1'b1;
    repeat (188) cycle(1'b1);
    pkt_rdy = 1'b0;
    repeat (2) cycle(1'b0);
    check("sync_rd_cnt", rd_cnt - rd_base, 188);
    check("sync_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
    check("sync_left", exp_q.size(), 0);

    // Three empty slots at byte 50; pkt_rdy drops mid-packet with no effect
    rd_base = rd_cnt;
    fill_pkt(8'h47, 8'h07);
    for (int k = 0; k < 188; k++) begin
      if (k >= 50 && k < 53) push_exp(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      else push_exp((k == 0) ? 8'h47 : pkt[(k < 50) ? k : k - 3], k == 0, k == 187,
                    1'b0, 1'b0, 1'b0);
    end
    pkt_rdy = 1'b1;
    for (int k = 0; k < 188; k++) begin
      force_empty = (k >= 50 && k < 53);
      cycle(1'b1);
      pkt_rdy = 1'b0;
    end
    force_empty = 1'b0;
    repeat (2) cycle(1'b0);
    check("urun_rd_cnt", rd_cnt - rd_base, 185);
    check("urun_fifo_left", fifo_q.size(), 3);
    check("urun_pkt_cnt", {16'd0, pkt_cnt}, 32'd4);
    check("urun_left", exp_q.size(), 0);
    fifo_q.delete();
    fifo_update();

    // Reset at byte 100 abandons the packet
    fill_pkt(8'h47, 8'h09);
    push_pkt(99);
    pkt_rdy = 1'b1;
    repeat (100) cycle(1'b1);
    rst = 1'b1;
    #1;
    check("rst_outputs", {ts_out, ts_out_valid, ts_out_sync, ts_out_last, ts_out_null,
                          sync_err, underrun, fifo_rd, pkt_cnt}, 32'd0);
    check("rst_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_q.delete();
    fill_pkt(8'h47, 8'h21);
    push_pkt(188);
    repeat (188) cycle(1'b1);
    pkt_rdy = 1'b0;
    repeat (2) cycle(1'b0);
    check("post_rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    check("post_rst_left", exp_q.size(), 0);
    check("post_rst_fifo", fifo_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
